// File: rtl/stopwatch_timer_pkg.sv
// Shared register map, control/status bit positions and helpers for the stopwatch timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_timer_pkg;

    localparam int TMR_CTRL     = 0;
    localparam int TMR_PRESCALE = 1;
    localparam int TMR_COUNT    = 2;
    localparam int TMR_COMPARE  = 3;
    localparam int TMR_STATUS   = 4;
    localparam int TMR_LAP      = 5;

    localparam int CTRL_RUN         = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_CLEAR       = 3;

    localparam int STAT_MATCH = 0;
    localparam int STAT_OVF   = 1;

    // Field order mirrors the CTRL bit layout so the struct packs onto bits [2:0].
    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic run;
    } ctrl_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdat[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts enabled clocks and pulses tick when the count reaches the reload value.
// Latency: tick is combinational from the counter state; counter restarts the cycle after restart.
// Backpressure: none; enable low freezes the counter.
module timer_prescaler #(
    parameter int PRESCALE_BITS = 24
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic                     restart,
    input  logic [PRESCALE_BITS-1:0] reload,
    output logic                     tick
);

    logic [PRESCALE_BITS-1:0] pcnt;

    assign tick = enable && (pcnt == reload);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pcnt <= '0;
        end else if (restart || tick) begin
            pcnt <= '0;
        end else if (enable) begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_timer.sv
// Memory-mapped prescaled 32-bit up-counter with compare, auto-reload, lap capture and level irq.
// Latency: ready/rdata one cycle after sel; COUNT advances on each prescaler tick.
// Backpressure: none; a new access is taken only after ready drops (2 cycles per access).
module stopwatch_timer
    import stopwatch_timer_pkg::*;
#(
    parameter int PRESCALE_BITS  = 24,
    parameter int PRESCALE_RESET = 11999,
    parameter int ADDR_BITS      = 6
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 sel,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    input  logic [3:0]           wstrb,
    output logic                 ready,
    output logic [31:0]          rdata,
    output logic                 irq,
    output logic                 tick
);

    ctrl_t                    ctrl;
    logic [PRESCALE_BITS-1:0] prescale;
    logic [31:0]              count;
    logic [31:0]              compare;
    logic [31:0]              lap;
    logic                     match_flag;
    logic                     ovf_flag;

    logic        access;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        wr_lap;
    logic        do_clear;
    logic        w1c_match;
    logic        w1c_ovf;
    logic [31:0] count_nxt;
    logic [32:0] count_inc;
    logic [31:0] rd_mux;
    logic        match_set;
    logic        ovf_set;

    assign access      = sel && !ready;
    assign wr          = access && (wstrb != 4'b0000);
    assign wr_ctrl     = wr && (addr == ADDR_BITS'(TMR_CTRL));
    assign wr_prescale = wr && (addr == ADDR_BITS'(TMR_PRESCALE));
    assign wr_count    = wr && (addr == ADDR_BITS'(TMR_COUNT));
    assign wr_compare  = wr && (addr == ADDR_BITS'(TMR_COMPARE));
    assign wr_status   = wr && (addr == ADDR_BITS'(TMR_STATUS));
    assign wr_lap      = wr && (addr == ADDR_BITS'(TMR_LAP));

    assign do_clear  = wr_ctrl && wstrb[0] && wdata[CTRL_CLEAR];
    assign w1c_match = wr_status && wstrb[0] && wdata[STAT_MATCH];
    assign w1c_ovf   = wr_status && wstrb[0] && wdata[STAT_OVF];
    assign count_inc = {1'b0, count} + 33'd1;
    assign irq       = ctrl.irq_en && (match_flag || ovf_flag);

    timer_prescaler #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_prescaler (
        .clock   (clock),
        .resetn  (resetn),
        .enable  (ctrl.run),
        .restart (wr_prescale || do_clear),
        .reload  (prescale),
        .tick    (tick)
    );

    // Bus writes and clear pre-empt the tick; a pre-empted tick neither counts nor matches.
    always_comb begin
        count_nxt = count;
        match_set = 1'b0;
        ovf_set   = 1'b0;
        if (wr_count) begin
            count_nxt = merge_bytes(count, wdata, wstrb);
        end else if (do_clear) begin
            count_nxt = '0;
        end else if (tick) begin
            match_set = (count == compare);
            if (match_set && ctrl.auto_reload) begin
                count_nxt = '0;
            end else begin
                count_nxt = count_inc[31:0];
                ovf_set   = count_inc[32];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_BITS'(TMR_CTRL):     rd_mux = {29'b0, ctrl};
            ADDR_BITS'(TMR_PRESCALE): rd_mux = 32'(prescale);
            ADDR_BITS'(TMR_COUNT):    rd_mux = count;
            ADDR_BITS'(TMR_COMPARE):  rd_mux = compare;
            ADDR_BITS'(TMR_STATUS):   rd_mux = {30'b0, ovf_flag, match_flag};
            ADDR_BITS'(TMR_LAP):      rd_mux = lap;
            default:                  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready      <= 1'b0;
            rdata      <= '0;
            ctrl       <= '0;
            prescale   <= PRESCALE_BITS'(PRESCALE_RESET);
            count      <= '0;
            compare    <= 32'hFFFF_FFFF;
            lap        <= '0;
            match_flag <= 1'b0;
            ovf_flag   <= 1'b0;
        end else begin
            ready <= access;
            rdata <= (access && !wr) ? rd_mux : '0;
            if (wr_ctrl && wstrb[0]) begin
                ctrl <= '{irq_en:      wdata[CTRL_IRQ_EN],
                          auto_reload: wdata[CTRL_AUTO_RELOAD],
                          run:         wdata[CTRL_RUN]};
            end
            if (wr_prescale) begin
                prescale <= PRESCALE_BITS'(merge_bytes(32'(prescale), wdata, wstrb));
            end
            count <= count_nxt;
            if (wr_compare) begin
                compare <= merge_bytes(compare, wdata, wstrb);
            end
            // count still holds the pre-tick value here, so a coincident lap sees it.
            if (wr_lap) begin
                lap <= count;
            end
            match_flag <= match_set || (match_flag && !w1c_match);
            ovf_flag   <= ovf_set   || (ovf_flag   && !w1c_ovf);
        end
    end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench for stopwatch_timer: a transaction-level model checked every cycle,
// plus hand-computed register readbacks at the interesting points.
module tb_stopwatch_timer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0;
    logic [5:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        ready;
    logic [31:0] rdata;
    logic        irq;
    logic        tick;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    stopwatch_timer dut (
        .clock  (clock),
        .resetn (resetn),
        .sel    (sel),
        .addr   (addr),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .ready  (ready),
        .rdata  (rdata),
        .irq    (irq),
        .tick   (tick)
    );

    // Programmer-visible state of the peripheral
    logic        m_run, m_auto, m_irqen;
    logic [23:0] m_pre, m_pcnt;
    logic [31:0] m_count, m_cmp, m_lap;
    logic        m_match, m_ovf;
    logic        m_ready;
    logic [31:0] m_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] cur, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_run = 0; m_auto = 0; m_irqen = 0;
        m_pre = 24'd11999; m_pcnt = '0;
        m_count = '0; m_cmp = 32'hFFFF_FFFF; m_lap = '0;
        m_match = 0; m_ovf = 0;
        m_ready = 0; m_rdata = '0;
    endtask

    task automatic model_step();
        logic        tk, acc, wr, clr, hit_m, hit_o;
        logic [31:0] old_count, rd, tmp;
        logic [32:0] inc;
        tk = m_run && (m_pcnt == m_pre);
        acc = sel && !m_ready;
        wr = acc && (wstrb != 4'b0000);
        clr = wr && (addr == 0) && wstrb[0] && wdata[3];
        old_count = m_count;
        case (addr)
            0: rd = {29'b0, m_irqen, m_auto, m_run};
            1: rd = {8'b0, m_pre};
            2: rd = m_count;
            3: rd = m_cmp;
            4: rd = {30'b0, m_ovf, m_match};
            5: rd = m_lap;
            default: rd = '0;
        endcase
        m_ready = acc;
        m_rdata = (acc && !wr) ? rd : 32'd0;
        hit_m = 0;
        hit_o = 0;
        if ((wr && addr == 1) || clr || tk) m_pcnt = '0;
        else if (m_run) m_pcnt = m_pcnt + 1;
        if (wr && addr == 2) m_count = bmerge(m_count, wdata, wstrb);
        else if (clr) m_count = '0;
        else if (tk) begin
            hit_m = (old_count == m_cmp);
            if (hit_m && m_auto) m_count = '0;
            else begin
                inc = {1'b0, old_count} + 33'd1;
                m_count = inc[31:0];
                hit_o = inc[32];
            end
        end
        if (wr && addr == 5) m_lap = old_count;
        if (wr && addr == 3) m_cmp = bmerge(m_cmp, wdata, wstrb);
        if (wr && addr == 1) begin
            tmp = bmerge({8'b0, m_pre}, wdata, wstrb);
            m_pre = tmp[23:0];
        end
        if (wr && addr == 4 && wstrb[0]) begin
            if (wdata[0]) m_match = 0;
            if (wdata[1]) m_ovf = 0;
        end
        if (hit_m) m_match = 1;
        if (hit_o) m_ovf = 1;
        if (wr && addr == 0 && wstrb[0]) {m_irqen, m_auto, m_run} = wdata[2:0];
    endtask

    always @(posedge clock or negedge resetn) begin
        if (!resetn) model_reset();
        else model_step();
    end

    always @(negedge clock) begin
        check("ready", {31'b0, ready}, {31'b0, m_ready});
        check("tick", {31'b0, tick}, {31'b0, m_run && (m_pcnt == m_pre)});
        check("irq", {31'b0, irq}, {31'b0, m_irqen && (m_match || m_ovf)});
        if (m_ready) check("rdata", rdata, m_rdata);
    end

    task automatic bus(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd);
        @(negedge clock);
        sel = 1'b1; addr = a; wdata = d; wstrb = s;
        @(negedge clock);
        check("ready_latency", {31'b0, ready}, 32'd1);
        rd = rdata;
        sel = 1'b0; wstrb = '0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(a, d, 4'hF, dummy);
    endtask

    task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus(a, 32'd0, 4'h0, v);
        check(name, v, exp);
    endtask

    task automatic check_reset_regs();
        rd_chk("rst_ctrl", 0, 32'd0);
        rd_chk("rst_prescale", 1, 32'd11999);
        rd_chk("rst_count", 2, 32'd0);
        rd_chk("rst_compare", 3, 32'hFFFF_FFFF);
        rd_chk("rst_status", 4, 32'd0);
        rd_chk("rst_lap", 5, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        check_reset_regs();
        rd_chk("unmapped_rd", 6, 32'd0);

        // Tick every 4 clocks: 40 clocks after run gives 10 counts.
        wr(1, 32'd3);
        wr(0, 32'd1);
        repeat (40) @(negedge clock);
        rd_chk("count_div4", 2, 32'd10);
        wr(0, 32'd0);

        // Auto-reload at COMPARE=5, match flag and irq, W1C.
        wr(1, 32'd0);
        wr(3, 32'd5);
        wr(0, 32'hF);
        repeat (10) @(negedge clock);
        rd_chk("ctrl_readback", 0, 32'd7);
        for (int i = 0; i < 4; i++) bus(2, 32'd0, 4'h0, v);
        rd_chk("status_match", 4, 32'd1);
        check("irq_on_match", {31'b0, irq}, 32'd1);
        wr(0, 32'd6);
        wr(4, 32'd1);
        check("irq_after_w1c", {31'b0, irq}, 32'd0);
        rd_chk("status_w1c", 4, 32'd0);
        wr(0, 32'd7);
        repeat (8) @(negedge clock);
        check("irq_rematch", {31'b0, irq}, 32'd1);

        // Wrap past FFFF_FFFF and count through COMPARE without reload.
        wr(0, 32'd0);
        wr(4, 32'd3);
        wr(3, 32'd1);
        wr(2, 32'hFFFF_FFFE);
        wr(0, 32'd1);
        repeat (2) @(negedge clock);
        wr(0, 32'd0);
        rd_chk("status_wrap", 4, 32'd3);
        rd_chk("count_wrap", 2, 32'd2);

        // COUNT write on a tick cycle wins; lap on a tick cycle sees pre-increment value.
        wr(0, 32'd1);
        wr(2, 32'd100);
        wr(0, 32'd0);
        rd_chk("count_wr_tick", 2, 32'd102);
        wr(0, 32'd1);
        wr(5, 32'd0);
        wr(0, 32'd0);
        rd_chk("lap_tick", 5, 32'd103);
        wr(6, 32'hDEAD_BEEF);
        rd_chk("unmapped_wr", 6, 32'd0);

        // Byte-lane write to COMPARE.
        wr(3, 32'hFFFF_FFFF);
        bus(3, 32'h0000_AB00, 4'b0010, v);
        rd_chk("compare_byte", 3, 32'hFFFF_ABFF);

        // Reset in the middle of an access.
        @(negedge clock);
        sel = 1'b1; addr = 6'd3; wstrb = 4'h0;
        @(posedge clock);
        #1;
        check("ready_pending", {31'b0, ready}, 32'd1);
        resetn = 1'b0;
        #1;
        check("ready_async_rst", {31'b0, ready}, 32'd0);
        sel = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check_reset_regs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
